// File: rtl/det_entry_ctrl_pkg.sv
// Shared definitions for the determinant run controller: state encoding,
// default sizes and the row/column to store-index mapping.
package det_ctrl_pkg;

  localparam int unsigned N_MAX_DEF = 8;
  localparam int unsigned DW_DEF    = 4;
  localparam int unsigned RW_DEF    = 32;

  // One-hot encoding so the q_* outputs map directly onto state bits.
  typedef enum logic [3:0] {
    S_INI   = 4'b0001,
    S_ENTER = 4'b0010,
    S_COMP  = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  // 8*row + col, independent of the active matrix size.
  function automatic logic [5:0] mat_idx(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/det_entry_ctrl_if.sv
// Front-end / engine / display signal bundle of det_entry_ctrl.
interface det_entry_ctrl_if #(
  parameter int unsigned N_MAX = 8,
  parameter int unsigned DW    = 4,
  parameter int unsigned RW    = 32
);
  logic                      Start;
  logic                      Ack;
  logic                      Enter;
  logic [3:0]                Size;
  logic [2:0]                Row;
  logic [2:0]                Col;
  logic [DW-1:0]             Din;
  logic [RW-1:0]             Det_In;
  logic                      Det_Done;
  logic                      Det_Start;
  logic [N_MAX*N_MAX*DW-1:0] Matrix_Flat;
  logic [DW-1:0]             Cur_Entry;
  logic [RW-1:0]             Det;
  logic [6:0]                Fill_Count;
  logic                      Range_Err;
  logic                      Timeout;
  logic                      q_I;
  logic                      q_Enter;
  logic                      q_Comp;
  logic                      q_Done;

  modport master (
    output Start, Ack, Enter, Size, Row, Col, Din, Det_In, Det_Done,
    input  Det_Start, Matrix_Flat, Cur_Entry, Det, Fill_Count, Range_Err, Timeout,
           q_I, q_Enter, q_Comp, q_Done
  );

  modport slave (
    input  Start, Ack, Enter, Size, Row, Col, Din, Det_In, Det_Done,
    output Det_Start, Matrix_Flat, Cur_Entry, Det, Fill_Count, Range_Err, Timeout,
           q_I, q_Enter, q_Comp, q_Done
  );
endinterface

// File: rtl/det_entry_ctrl_matrix_store.sv
// 64-entry matrix register file with synchronous clear, fill bitmap and
// distinct-entry counter, flat output and combinational read port.
module matrix_store
  import det_ctrl_pkg::*;
#(
  parameter int unsigned N_MAX = N_MAX_DEF,
  parameter int unsigned DW    = DW_DEF,
  localparam int unsigned DEPTH = N_MAX * N_MAX,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DW-1:0]       wdata,
  input  logic [AW-1:0]       raddr,
  output logic [DW-1:0]       rdata,
  output logic [DEPTH*DW-1:0] flat,
  output logic [6:0]          fill_count
);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [6:0]       cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      filled <= '0;
      cnt    <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
      // Only first writes to an entry count; rewrites just replace the value.
      if (!filled[waddr]) begin
        filled[waddr] <= 1'b1;
        if (cnt != 7'(DEPTH)) begin
          cnt <= cnt + 7'd1;
        end
      end
    end
  end

  always_comb begin
    flat = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      flat[i*DW +: DW] = mem[i];
    end
  end

  assign rdata      = mem[raddr];
  assign fill_count = cnt;

endmodule

// File: rtl/det_entry_ctrl.sv
// Run controller for the determinant datapath: entry capture, engine launch,
// result hold. Optional compute watchdog enabled by DETCTRL_TIMEOUT_EN.
module det_entry_ctrl
  import det_ctrl_pkg::*;
#(
  parameter int unsigned N_MAX          = N_MAX_DEF,
  parameter int unsigned DW             = DW_DEF,
  parameter int unsigned RW             = RW_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic           Clk,
  input  logic           Reset,
  det_entry_ctrl_if.slave bus
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_t        state, state_nx;
  logic [3:0]    size_q;
  logic [6:0]    size_sq;
  logic [RW-1:0] det_q;
  logic          det_start_q;
  logic          range_q;
  logic          start_ok;
  logic          in_range;
  logic          run_clr;
  logic          wr_en;
  logic          done_ok;
  logic          expire;
  logic [5:0]    idx;

  assign size_sq  = 7'(size_q) * 7'(size_q);
  assign start_ok = bus.Start && (bus.Size != 4'd0) && (bus.Size <= 4'(N_MAX));
  assign in_range = ({1'b0, bus.Row} < size_q) && ({1'b0, bus.Col} < size_q);
  assign run_clr  = (state == S_INI) && start_ok;
  assign wr_en    = (state == S_ENTER) && bus.Enter && in_range;
  // The engine needs at least one cycle, so a done during the launch cycle is stale.
  assign done_ok  = (state == S_COMP) && bus.Det_Done && !det_start_q;
  assign idx      = mat_idx(bus.Row, bus.Col);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_INI:   if (start_ok) state_nx = S_ENTER;
      S_ENTER: if (!bus.Enter && bus.Start && (bus.Fill_Count == size_sq)) state_nx = S_COMP;
      S_COMP:  if (done_ok || expire) state_nx = S_DONE;
      S_DONE:  if (bus.Ack) state_nx = S_INI;
      default: state_nx = S_INI;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_INI;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      size_q      <= '0;
      det_q       <= '0;
      det_start_q <= 1'b0;
      range_q     <= 1'b0;
    end else begin
      det_start_q <= (state == S_ENTER) && (state_nx == S_COMP);
      if (run_clr) begin
        size_q  <= bus.Size;
        det_q   <= '0;
        range_q <= 1'b0;
      end
      if ((state == S_ENTER) && bus.Enter && !in_range) begin
        range_q <= 1'b1;
      end
      if (done_ok) begin
        det_q <= bus.Det_In;
      end else if (expire) begin
        det_q <= '0;
      end
    end
  end

`ifdef DETCTRL_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_cnt;
  logic          to_q;

  assign expire = (state == S_COMP) && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else begin
      to_cnt <= (state == S_COMP) ? to_cnt + CW'(1) : '0;
      if (run_clr) begin
        to_q <= 1'b0;
      end else if (expire && !done_ok) begin
        to_q <= 1'b1;
      end
    end
  end

  assign bus.Timeout = to_q;
`else
  assign expire      = 1'b0;
  assign bus.Timeout = 1'b0;
`endif

  matrix_store #(
    .N_MAX (N_MAX),
    .DW    (DW)
  ) u_store (
    .clk        (Clk),
    .rst        (Reset),
    .clr        (run_clr),
    .we         (wr_en),
    .waddr      (idx),
    .wdata      (bus.Din),
    .raddr      (idx),
    .rdata      (bus.Cur_Entry),
    .flat       (bus.Matrix_Flat),
    .fill_count (bus.Fill_Count)
  );

  assign bus.Det       = det_q;
  assign bus.Det_Start = det_start_q;
  assign bus.Range_Err = range_q;
  assign bus.q_I       = (state == S_INI);
  assign bus.q_Enter   = (state == S_ENTER);
  assign bus.q_Comp    = (state == S_COMP);
  assign bus.q_Done    = (state == S_DONE);

endmodule

// File: tb/tb_det_entry_ctrl.sv
// Directed and randomized checks of det_entry_ctrl against a per-cycle
// behavioural model built from the run rules.
module tb_det_entry_ctrl;

`ifdef DETCTRL_TIMEOUT_EN
  localparam int TO    = 16;
  localparam bit TIMED = 1'b1;
`else
  localparam int TO    = 1024;
  localparam bit TIMED = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  det_entry_ctrl_if #(.N_MAX(8), .DW(4), .RW(32)) bus ();

  det_entry_ctrl #(
    .N_MAX          (8),
    .DW             (4),
    .RW             (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Model: 0=INI 1=ENTER 2=COMP 3=DONE
  int        m_state;
  int        m_size;
  bit [3:0]  m_mat [64];
  bit        m_filled [64];
  bit        m_range, m_to;
  bit [31:0] m_det;
  int        m_age;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_fill();
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(m_filled[i]);
    return n;
  endfunction

  function automatic logic [255:0] m_flat();
    logic [255:0] f = '0;
    for (int i = 0; i < 64; i++) f[i*4 +: 4] = m_mat[i];
    return f;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 64; i++) begin
      m_mat[i]    = '0;
      m_filled[i] = 1'b0;
    end
  endtask

  task automatic step(input bit rst, st, ak, en, input int sz, r, c, dn,
                      input bit [31:0] di, input bit dd);
    if (rst) begin
      m_state = 0; m_size = 0; m_clear();
      m_range = 0; m_to = 0; m_det = '0; m_age = 0;
    end else begin
      case (m_state)
        0: if (st && sz >= 1 && sz <= 8) begin
             m_state = 1; m_size = sz; m_clear();
             m_range = 0; m_to = 0; m_det = '0;
           end
        1: if (en) begin
             if (r < m_size && c < m_size) begin
               m_mat[8*r+c] = 4'(dn);
               m_filled[8*r+c] = 1'b1;
             end else begin
               m_range = 1'b1;
             end
           end else if (st && m_fill() == (m_size * m_size) % 128) begin
             m_state = 2; m_age = 0;
           end
        2: if (dd && m_age > 0) begin
             m_det = di; m_state = 3;
           end else if (TIMED && m_age + 1 == TO) begin
             m_det = '0; m_to = 1'b1; m_state = 3;
           end else begin
             m_age++;
           end
        default: if (ak) m_state = 0;
      endcase
    end
  endtask

  task automatic check_all(input string p);
    chk({p, ":q"}, {bus.q_Done, bus.q_Comp, bus.q_Enter, bus.q_I}, 256'(1) << m_state);
    chk({p, ":det_start"}, bus.Det_Start, (m_state == 2 && m_age == 0));
    chk({p, ":det"}, bus.Det, m_det);
    chk({p, ":fill"}, bus.Fill_Count, m_fill());
    chk({p, ":range"}, bus.Range_Err, m_range);
    chk({p, ":timeout"}, bus.Timeout, m_to);
    chk({p, ":cur"}, bus.Cur_Entry, m_mat[8*int'(bus.Row) + int'(bus.Col)]);
    chk({p, ":flat"}, bus.Matrix_Flat, m_flat());
  endtask

  task automatic tick(input bit rst, st, ak, en, input int sz, r, c, dn,
                      input logic [31:0] di, input bit dd, input string tag);
    Reset        = rst;
    bus.Start    = st;
    bus.Ack      = ak;
    bus.Enter    = en;
    bus.Size     = 4'(sz);
    bus.Row      = 3'(r);
    bus.Col      = 3'(c);
    bus.Din      = 4'(dn);
    bus.Det_In   = di;
    bus.Det_Done = dd;
    @(posedge Clk);
    step(rst, st, ak, en, sz, r, c, dn, di, dd);
    #1;
    Reset = 1'b0; bus.Start = 1'b0; bus.Ack = 1'b0; bus.Enter = 1'b0; bus.Det_Done = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();               tick(1, 0, 0, 0, 0, 0, 0, 0, '0, 0, "reset"); endtask
  task automatic do_start(input int sz);   tick(0, 1, 0, 0, sz, 0, 0, 0, '0, 0, "start"); endtask
  task automatic do_enter(input int r, c, d); tick(0, 0, 0, 1, 0, r, c, d, '0, 0, "enter"); endtask
  task automatic do_idle();                tick(0, 0, 0, 0, 0, 0, 0, 0, '0, 0, "idle"); endtask
  task automatic do_done(input logic [31:0] v); tick(0, 0, 0, 0, 0, 0, 0, 0, v, 1, "done"); endtask
  task automatic do_ack();                 tick(0, 0, 1, 0, 0, 0, 0, 0, '0, 0, "ack"); endtask

  initial begin
    Reset = 1'b1; bus.Start = 0; bus.Ack = 0; bus.Enter = 0; bus.Size = '0;
    bus.Row = '0; bus.Col = '0; bus.Din = '0; bus.Det_In = '0; bus.Det_Done = 0;

    do_reset();
    chk("reset_qI", bus.q_I, 1);
    chk("reset_flat", bus.Matrix_Flat, '0);

    // Full 2x2 run
    do_start(2);
    do_enter(0, 0, 3); do_enter(0, 1, 1); do_enter(1, 0, 2); do_enter(1, 1, 4);
    chk("full_fill", bus.Fill_Count, 4);
    do_start(2);
    chk("full_launch", bus.Det_Start, 1);
    do_idle();
    chk("full_launch_len", bus.Det_Start, 0);
    do_done(32'd10);
    chk("full_det", bus.Det, 32'h0000000A);
    chk("full_qdone", bus.q_Done, 1);
    do_ack();
    chk("full_qI", bus.q_I, 1);
    chk("full_det_hold", bus.Det, 32'h0000000A);

    // Incomplete matrix, then collision on the last entry
    do_start(2);
    chk("new_run_det_clr", bus.Det, 0);
    do_enter(0, 0, 1); do_enter(0, 1, 2); do_enter(1, 0, 3);
    do_start(2);
    chk("incomplete_qenter", bus.q_Enter, 1);
    chk("incomplete_dstart", bus.Det_Start, 0);
    chk("incomplete_fill", bus.Fill_Count, 3);
    tick(0, 1, 0, 1, 2, 1, 1, 6, '0, 0, "collide");
    chk("collide_qenter", bus.q_Enter, 1);
    chk("collide_entry", bus.Cur_Entry, 6);
    do_start(2);
    chk("collide_comp", bus.q_Comp, 1);
    do_done(32'h1234);
    chk("early_done_ignored", bus.q_Comp, 1);

    // Reset mid-COMP, then a late done
    do_reset();
    chk("midreset_qI", bus.q_I, 1);
    chk("midreset_det", bus.Det, 0);
    chk("midreset_flat", bus.Matrix_Flat, '0);
    chk("midreset_dstart", bus.Det_Start, 0);
    do_done(32'h55);
    chk("late_done_det", bus.Det, 0);

    // Range error and rewrite
    do_start(2);
    do_enter(2, 0, 5); do_enter(1, 1, 7); do_enter(1, 1, 9);
    chk("range_err", bus.Range_Err, 1);
    chk("rewrite_idx9", bus.Matrix_Flat[39:36], 9);
    chk("rewrite_fill", bus.Fill_Count, 1);
    do_reset();

    // Bad sizes
    do_start(0);
    chk("size0_qI", bus.q_I, 1);
    do_start(9);
    chk("size9_qI", bus.q_I, 1);

    // Watchdog behaviour
    do_start(1); do_enter(0, 0, 5); do_start(1);
    if (TIMED) begin
      for (int i = 0; i < TO - 1; i++) do_idle();
      chk("to_before", bus.q_Comp, 1);
      do_idle();
      chk("to_qdone", bus.q_Done, 1);
      chk("to_flag", bus.Timeout, 1);
      chk("to_det", bus.Det, 0);
      do_ack();
      do_start(1); do_enter(0, 0, 2); do_start(1);
      for (int i = 0; i < TO - 1; i++) do_idle();
      do_done(32'hCAFE);
      chk("to_race_det", bus.Det, 32'hCAFE);
      chk("to_race_flag", bus.Timeout, 0);
    end else begin
      for (int i = 0; i < 40; i++) do_idle();
      chk("nowd_comp", bus.q_Comp, 1);
      chk("nowd_flag", bus.Timeout, 0);
      do_done(32'hBEEF);
      chk("nowd_det", bus.Det, 32'hBEEF);
    end
    do_ack();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit rst, st, ak, en, dd;
      int sz, r, c;
      rst = ($urandom_range(0, 299) == 0);
      st  = ($urandom_range(0, 7) == 0);
      ak  = ($urandom_range(0, 3) == 0);
      en  = ($urandom_range(0, 1) == 0);
      dd  = ($urandom_range(0, 5) == 0);
      sz  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 3));
      r   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
      c   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
      tick(rst, st, ak, en, sz, r, c, int'($urandom_range(0, 15)), $urandom, dd, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
